// File: rtl/data_mem_param_if.sv
// Request/response bundle between the load/store unit (master) and data_mem_param (slave).
interface data_mem_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) ();
   logic                  req_valid;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  clear_req;
   logic                  ready;
   logic                  rd_valid;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_err;
   logic                  wr_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, clear_req,
      input  ready, rd_valid, rd_data, rd_err, wr_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, clear_req,
      output ready, rd_valid, rd_data, rd_err, wr_err
   );
endinterface

// File: rtl/data_mem_param.sv
// Parametrised single-port data RAM with byte enables, registered valid-qualified read,
// a hardware clear engine and out-of-range address detection.
module data_mem_param #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int DEPTH          = 256,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_param_if.slave   bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_e;
   localparam state_e RESET_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              ready_q, ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;
   logic              wr_err_q, wr_err_d;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wdata;
   logic [NB-1:0]     mem_be;

   logic              in_range;
   logic [IDX_W-1:0]  req_idx;
   logic [DATA_W-1:0] rd_word;

   // Compare on the full address so nothing above DEPTH-1 aliases into the array.
   assign in_range = ({1'b0, bus.req_addr} < DEPTH_C);
   assign req_idx  = bus.req_addr[IDX_W-1:0];
   assign rd_word  = mem_q[req_idx];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ready_d    = ready_q;
      rd_valid_d = 1'b0;
      rd_data_d  = '0;
      rd_err_d   = 1'b0;
      wr_err_d   = 1'b0;
      mem_we     = 1'b0;
      mem_idx    = ptr_q;
      mem_wdata  = '0;
      mem_be     = '1;
      case (state_q)
         ST_CLEAR: begin
            mem_we  = 1'b1;
            ready_d = 1'b0;
            if (ptr_q == LAST_IDX) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
               ready_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            ready_d = 1'b1;
            if (bus.clear_req) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
               ready_d = 1'b0;
            end else if (bus.req_valid && ready_q) begin
               if (bus.req_write) begin
                  if (in_range) begin
                     mem_we    = 1'b1;
                     mem_idx   = req_idx;
                     mem_wdata = bus.req_wdata;
                     mem_be    = bus.req_be;
                  end else begin
                     wr_err_d = 1'b1;
                  end
               end else begin
                  rd_valid_d = 1'b1;
                  if (in_range) rd_data_d = rd_word;
                  else          rd_err_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RESET_ST;
         ptr_q      <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
         wr_err_q   <= wr_err_d;
      end
   end

   // While reset is held in clear mode only word 0 is touched, and the restarted clear zeroes it first.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   assign bus.ready    = ready_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_err   = rd_err_q;
   assign bus.wr_err   = wr_err_q;
endmodule
